regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/rv32i_types.sv | 16 +
 rtl/wb_scoreboard.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I writeback types: register index, data word and arbiter state.
package rv32i_types;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NREGS  = 32;

  typedef logic [REG_W-1:0]  rv32i_reg;
  typedef logic [WORD_W-1:0] rv32i_word;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_HELD  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for MDU destinations; flags decode sources that must wait.
module wb_scoreboard
  import rv32i_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     issue_valid,
  input  rv32i_reg issue_dest,
  input  logic     clr_valid,
  input  rv32i_reg clr_dest,
  input  rv32i_reg src_a,
  input  rv32i_reg src_b,
  output logic     busy_a,
  output logic     busy_b
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  // Clear is applied before set so a same-cycle reissue keeps the bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_dest != '0)) set_mask[issue_dest] = 1'b1;
    if (clr_valid) clr_mask[clr_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | set_mask;
  end

  assign busy_a = !rst && (src_a != '0) && pending[src_a];
  assign busy_b = !rst && (src_b != '0) && pending[src_b];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline and MDU results onto the single regfile write port, buffering one MDU result.
// WB_STARVE_GUARD_EN adds a wait counter that stalls the pipeline to drain a starved buffer.
module regfile_wb_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pipe_valid,
  input  rv32i_reg  pipe_dest,
  input  rv32i_word pipe_data,
  input  logic      mdu_valid,
  input  rv32i_reg  mdu_dest,
  input  rv32i_word mdu_data,
  output logic      mdu_ready,
  input  logic      issue_valid,
  input  rv32i_reg  issue_dest,
  input  rv32i_reg  src_a,
  input  rv32i_reg  src_b,
  output logic      busy_a,
  output logic      busy_b,
  output logic      pipe_stall,
  output logic      rf_load,
  output rv32i_reg  rf_dest,
  output rv32i_word rf_in
);

  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_e state;
  rv32i_reg   buf_dest;
  rv32i_word  buf_data;
  logic       stall_q;
  logic       handshake;
  logic       mdu_wr;
  logic       capture;
  logic       drain;

  assign mdu_ready  = (state == ARB_EMPTY) && !rst;
  assign handshake  = mdu_valid && mdu_ready;
  assign pipe_stall = stall_q && !rst;

  // Grant selection: pipe has priority except when the held result must drain.
  always_comb begin
    rf_load = 1'b0;
    rf_dest = '0;
    rf_in   = '0;
    mdu_wr  = 1'b0;
    capture = 1'b0;
    drain   = 1'b0;
    if (!rst) begin
      case (state)
        ARB_EMPTY: begin
          if (pipe_valid) begin
            rf_load = 1'b1;
            rf_dest = pipe_dest;
            rf_in   = pipe_data;
            capture = handshake;
          end else if (handshake) begin
            rf_load = 1'b1;
            rf_dest = mdu_dest;
            rf_in   = mdu_data;
            mdu_wr  = 1'b1;
          end
        end
        ARB_HELD: begin
          if (stall_q || !pipe_valid) begin
            rf_load = 1'b1;
            rf_dest = buf_dest;
            rf_in   = buf_data;
            mdu_wr  = 1'b1;
            drain   = 1'b1;
          end else begin
            rf_load = 1'b1;
            rf_dest = pipe_dest;
            rf_in   = pipe_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_EMPTY;
      buf_dest <= '0;
      buf_data <= '0;
    end else if (capture) begin
      state    <= ARB_HELD;
      buf_dest <= mdu_dest;
      buf_data <= mdu_data;
    end else if (drain) begin
      state    <= ARB_EMPTY;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic             waiting;

  // Count HELD cycles that pass without draining; saturates at the limit.
  assign waiting = (state == ARB_HELD) && !drain && !rst;

  always_comb begin
    wait_nxt = '0;
    if (waiting) wait_nxt = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      stall_q  <= waiting && (wait_nxt == LIMIT);
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .clr_valid   (mdu_wr),
    .clr_dest    (rf_dest),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy_a      (busy_a),
    .busy_b      (busy_b)
  );

endmodule
